// File: rtl/delta_pkg.sv
// Shared constants for the delta-modulation spike encoder.
package delta_pkg;

    // Reference-update modes
    localparam logic MODE_SAMPLE = 1'b0;  // reference follows every valid sample
    localparam logic MODE_TRACK  = 1'b1;  // reference steps by threshold on a spike

    // Default widths
    localparam int DEF_DATA_W   = 4;
    localparam int DEF_NUM_CH   = 2;
    localparam int DEF_REFRAC_W = 3;
    localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/delta_channel.sv
// One encoder channel: signed delta compare against the reference, reference
// register, refractory down-counter and registered up/down spikes.
// hit_up/hit_dn are the spikes that will be registered on the next edge; the
// top level counts them so the spike counter lines up with spike_valid.
module delta_channel
    import delta_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REFRAC_W = DEF_REFRAC_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic                load_ref,
    input  logic [DATA_W-1:0]   load_val,
    input  logic [DATA_W-1:0]   sample,
    input  logic [DATA_W-1:0]   threshold,
    input  logic                mode,
    input  logic                off_spike,
    input  logic [REFRAC_W-1:0] refrac_len,
    output logic                hit_up,
    output logic                hit_dn,
    output logic                spike_up,
    output logic                spike_dn,
    output logic [DATA_W-1:0]   ref_val
);

    localparam logic [DATA_W-1:0] REF_MAX = '1;

    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] thr_s;
    logic                   up_cond;
    logic                   dn_cond;
    logic                   in_refrac;
    logic [DATA_W:0]        ref_sum;
    logic [DATA_W-1:0]      ref_next;
    logic [REFRAC_W-1:0]    refrac_q;
    logic [REFRAC_W-1:0]    refrac_next;

    // Delta compare; both operands zero-extended so the difference never overflows
    always_comb begin
        diff      = $signed({1'b0, sample}) - $signed({1'b0, ref_val});
        thr_s     = $signed({1'b0, threshold});
        up_cond   = diff > thr_s;
        dn_cond   = off_spike && ((-diff) > thr_s);
        in_refrac = (refrac_q != '0);
        hit_up    = sample_valid && !load_ref && !in_refrac && up_cond;
        hit_dn    = sample_valid && !load_ref && !in_refrac && dn_cond;
    end

    // Next reference and refractory count; load_ref overrides any sample
    always_comb begin
        ref_sum     = {1'b0, ref_val} + {1'b0, threshold};
        ref_next    = ref_val;
        refrac_next = refrac_q;
        if (load_ref) begin
            ref_next    = load_val;
            refrac_next = '0;
        end else if (sample_valid) begin
            if (in_refrac) begin
                refrac_next = refrac_q - REFRAC_W'(1);
            end else if (hit_up || hit_dn) begin
                refrac_next = refrac_len;
            end

            if (mode == MODE_SAMPLE) begin
                ref_next = sample;
            end else if (hit_up) begin
                ref_next = ref_sum[DATA_W] ? REF_MAX : ref_sum[DATA_W-1:0];
            end else if (hit_dn) begin
                ref_next = (threshold > ref_val) ? '0 : (ref_val - threshold);
            end
        end
    end

    // Channel state and registered spike outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_val  <= '0;
            refrac_q <= '0;
            spike_up <= 1'b0;
            spike_dn <= 1'b0;
        end else begin
            ref_val  <= ref_next;
            refrac_q <= refrac_next;
            spike_up <= hit_up;
            spike_dn <= hit_dn;
        end
    end

endmodule

// File: rtl/delta_spike_encoder.sv
// Multi-channel delta-modulation spike encoder: per-channel encoders, load_ref
// fan-out, spike_valid register and saturating spike counter.
module delta_spike_encoder
    import delta_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int REFRAC_W = DEF_REFRAC_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0]        threshold,
    input  logic                     mode,
    input  logic                     off_spike,
    input  logic [REFRAC_W-1:0]      refrac_len,
    input  logic                     load_ref,
    input  logic [DATA_W-1:0]        load_val,
    output logic [NUM_CH-1:0]        spike_up,
    output logic [NUM_CH-1:0]        spike_dn,
    output logic                     spike_valid,
    output logic [NUM_CH*DATA_W-1:0] ref_out,
    output logic [CNT_W-1:0]         spike_cnt
);

    localparam int PC_W  = $clog2(NUM_CH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] hit_up;
    logic [NUM_CH-1:0] hit_dn;
    logic [PC_W-1:0]   hit_cnt;
    logic [SUM_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_next;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        delta_channel #(
            .DATA_W   (DATA_W),
            .REFRAC_W (REFRAC_W)
        ) u_channel (
            .clk          (clk),
            .rst_n        (rst_n),
            .sample_valid (in_valid),
            .load_ref     (load_ref),
            .load_val     (load_val),
            .sample       (in_data[ch*DATA_W +: DATA_W]),
            .threshold    (threshold),
            .mode         (mode),
            .off_spike    (off_spike),
            .refrac_len   (refrac_len),
            .hit_up       (hit_up[ch]),
            .hit_dn       (hit_dn[ch]),
            .spike_up     (spike_up[ch]),
            .spike_dn     (spike_dn[ch]),
            .ref_val      (ref_out[ch*DATA_W +: DATA_W])
        );
    end

    // Count the spikes about to be emitted and add them with saturation
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit_cnt = hit_cnt + PC_W'(hit_up[i] | hit_dn[i]);
        end
        cnt_sum  = SUM_W'(spike_cnt) + SUM_W'(hit_cnt);
        cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    // A sample set dropped by load_ref produces no valid output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_valid <= 1'b0;
            spike_cnt   <= '0;
        end else begin
            spike_valid <= in_valid && !load_ref;
            spike_cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_delta_spike_encoder.sv
// Self-checking bench for delta_spike_encoder: directed steps followed by a
// random stream, all compared against an arithmetic reference model.
module tb_delta_spike_encoder;

    localparam int DATA_W   = 4;
    localparam int NUM_CH   = 2;
    localparam int REFRAC_W = 3;
    localparam int CNT_W    = 3;
    localparam int DMAX     = (1 << DATA_W) - 1;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic [NUM_CH*DATA_W-1:0] in_data = '0;
    logic [DATA_W-1:0]        threshold = '0;
    logic                     mode = 1'b0;
    logic                     off_spike = 1'b0;
    logic [REFRAC_W-1:0]      refrac_len = '0;
    logic                     load_ref = 1'b0;
    logic [DATA_W-1:0]        load_val = '0;
    logic [NUM_CH-1:0]        spike_up;
    logic [NUM_CH-1:0]        spike_dn;
    logic                     spike_valid;
    logic [NUM_CH*DATA_W-1:0] ref_out;
    logic [CNT_W-1:0]         spike_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int                       ref_m [NUM_CH];
    int                       rc_m  [NUM_CH];
    int                       cnt_m;
    logic [NUM_CH-1:0]        exp_up;
    logic [NUM_CH-1:0]        exp_dn;
    logic                     exp_valid;
    logic [NUM_CH*DATA_W-1:0] exp_ref;

    delta_spike_encoder #(
        .DATA_W   (DATA_W),
        .NUM_CH   (NUM_CH),
        .REFRAC_W (REFRAC_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .threshold   (threshold),
        .mode        (mode),
        .off_spike   (off_spike),
        .refrac_len  (refrac_len),
        .load_ref    (load_ref),
        .load_val    (load_val),
        .spike_up    (spike_up),
        .spike_dn    (spike_dn),
        .spike_valid (spike_valid),
        .ref_out     (ref_out),
        .spike_cnt   (spike_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            ref_m[c] = 0;
            rc_m[c]  = 0;
        end
        cnt_m     = 0;
        exp_up    = '0;
        exp_dn    = '0;
        exp_valid = 1'b0;
    endtask

    // Apply the encoder rules to one input cycle
    task automatic model_step(input logic v, input logic [NUM_CH*DATA_W-1:0] d,
                              input int thr, input logic md, input logic off,
                              input int rl, input logic ld, input int lv);
        int s, diff, pop;
        logic up, dn;
        exp_up    = '0;
        exp_dn    = '0;
        exp_valid = 1'b0;
        if (ld) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ref_m[c] = lv;
                rc_m[c]  = 0;
            end
        end else if (v) begin
            exp_valid = 1'b1;
            pop = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                s    = int'(d[c*DATA_W +: DATA_W]);
                diff = s - ref_m[c];
                up   = diff > thr;
                dn   = off && (-diff > thr);
                if (rc_m[c] > 0) begin
                    up = 1'b0;
                    dn = 1'b0;
                    rc_m[c] = rc_m[c] - 1;
                end else if (up || dn) begin
                    rc_m[c] = rl;
                end
                if (md == 1'b0)  ref_m[c] = s;
                else if (up)     ref_m[c] = (ref_m[c] + thr > DMAX) ? DMAX : ref_m[c] + thr;
                else if (dn)     ref_m[c] = (ref_m[c] - thr < 0) ? 0 : ref_m[c] - thr;
                exp_up[c] = up;
                exp_dn[c] = dn;
                pop += int'(up) + int'(dn);
            end
            cnt_m = (cnt_m + pop > CMAX) ? CMAX : cnt_m + pop;
        end
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NUM_CH; c++) exp_ref[c*DATA_W +: DATA_W] = DATA_W'(ref_m[c]);
        chk({tag, "_valid"}, 32'(spike_valid), 32'(exp_valid));
        chk({tag, "_up"},    32'(spike_up),    32'(exp_up));
        chk({tag, "_dn"},    32'(spike_dn),    32'(exp_dn));
        chk({tag, "_ref"},   32'(ref_out),     32'(exp_ref));
        chk({tag, "_cnt"},   32'(spike_cnt),   32'(cnt_m));
    endtask

    // Drive one input cycle, let the edge pass, then compare against the model
    task automatic step(input string tag, input logic v, input logic [NUM_CH*DATA_W-1:0] d,
                        input int thr, input logic md, input logic off, input int rl,
                        input logic ld, input int lv);
        in_valid   = v;
        in_data    = d;
        threshold  = DATA_W'(thr);
        mode       = md;
        off_spike  = off;
        refrac_len = REFRAC_W'(rl);
        load_ref   = ld;
        load_val   = DATA_W'(lv);
        @(posedge clk);
        model_step(v, d, thr, md, off, rl, ld, lv);
        #1;
        check_all(tag);
    endtask

    // Pull reset low between edges and check that outputs clear at once
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        in_valid = 1'b0;
        load_ref = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("rst_out");

        // 1: first sample compares against ref=0
        step("t1", 1, {4'd0, 4'd5}, 3, 0, 1, 0, 0, 0);
        chk("t1_up_const", 32'(spike_up), 32'h1);
        chk("t1_cnt_const", 32'(spike_cnt), 32'h1);

        // 2: down spike gating in SAMPLE mode
        step("t2_ld", 0, 8'h00, 3, 0, 1, 0, 1, 9);
        step("t2_dn", 1, {4'd9, 4'd2}, 3, 0, 1, 0, 0, 0);
        chk("t2_dn_const", 32'(spike_dn), 32'h1);
        step("t2_ld2", 0, 8'h00, 3, 0, 1, 0, 1, 9);
        step("t2_off", 1, {4'd9, 4'd2}, 3, 0, 0, 0, 0, 0);
        chk("t2_off_ref", 32'(ref_out[3:0]), 32'h2);

        // 3: TRACK saturation and zero threshold
        step("t3_ld", 0, 8'h00, 0, 1, 1, 0, 1, 14);
        step("t3_up", 1, {4'd14, 4'd15}, 0, 1, 1, 0, 0, 0);
        chk("t3_ref_hold", 32'(ref_out[3:0]), 32'hE);
        step("t3_dn", 1, {4'd14, 4'd0}, 3, 1, 1, 0, 0, 0);
        chk("t3_ref_step", 32'(ref_out[3:0]), 32'hB);

        // 4: refractory suppression
        step("t4_ld", 0, 8'h00, 3, 0, 1, 2, 1, 0);
        step("t4_s1", 1, {4'd0, 4'd8}, 3, 0, 1, 2, 0, 0);
        step("t4_s2", 1, {4'd0, 4'd0}, 3, 0, 1, 2, 0, 0);
        step("t4_s3", 1, {4'd0, 4'd8}, 3, 0, 1, 2, 0, 0);
        chk("t4_s3_quiet", 32'(spike_up), 32'h0);
        step("t4_s4", 1, {4'd0, 4'd0}, 3, 0, 1, 2, 0, 0);
        chk("t4_s4_dn", 32'(spike_dn), 32'h1);

        // 5: load_ref drops a coincident sample and clears refractory
        step("t5_arm", 1, {4'd0, 4'd15}, 3, 0, 1, 7, 0, 0);
        step("t5_ld", 1, {4'd15, 4'd15}, 3, 0, 1, 7, 1, 7);
        chk("t5_ref_const", 32'(ref_out), 32'h77);
        step("t5_post", 1, {4'd7, 4'd15}, 3, 0, 1, 7, 0, 0);

        // 6: counter saturation, then reset mid-stream
        async_reset("t6_rst0");
        for (int i = 0; i < 5; i++)
            step("t6_sat", 1, (i % 2 == 0) ? 8'hFF : 8'h00, 0, 0, 1, 0, 0, 0);
        chk("t6_cnt_const", 32'(spike_cnt), 32'h7);
        step("t6_hold", 1, 8'hFF, 0, 0, 1, 0, 0, 0);
        async_reset("t6_rst1");

        // Random stream against the model
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset("rnd_rst");
            step("rnd", ($urandom_range(0, 9) < 7),
                 8'($urandom),
                 int'($urandom_range(0, 6)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, DMAX)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
